aes_key_expansion_iter: RTL and testbench

Iterative AES key expander supporting AES-128, AES-192 and AES-256, with the mode selected per key at runtime. It produces one 32-bit schedule word per cycle into an internal round-key store. Results are exposed on an indexed read port and on a flat 15-round-key bus. It is a multi-mode, handshaked successor to the fixed AES-256 key_expansion and sits between the key-load interface and the cipher round datapath.

---
 rtl/aes_pkg.sv | 69 ++++++
 rtl/aes_sbox.sv | 29 ++
 rtl/aes_key_expansion_iter.sv | 186 ++++++++++++++++++
 tb/tb_aes_key_expansion_iter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types, mode constants and small helpers for the AES key schedule.
package aes_pkg;

  // Key-size selector; the encoding 2'b11 is folded onto AES-256 when decoded.
  typedef enum logic [1:0] {
    MODE_128 = 2'b00,
    MODE_192 = 2'b01,
    MODE_256 = 2'b10
  } mode_e;

  // Expander control states.
  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    SUBW,
    DONE
  } state_e;

  localparam int         MAX_WORDS = 60;
  localparam int         MAX_RKEYS = 15;
  localparam logic [7:0] RCON_INIT = 8'h01;

  // Map the raw mode field to a legal mode.
  function automatic mode_e mode_decode_f(input logic [1:0] m);
    case (m)
      2'b00:   return MODE_128;
      2'b01:   return MODE_192;
      default: return MODE_256;
    endcase
  endfunction

  // Key length in 32-bit words.
  function automatic logic [3:0] nk_f(input mode_e m);
    case (m)
      MODE_128: return 4'd4;
      MODE_192: return 4'd6;
      default:  return 4'd8;
    endcase
  endfunction

  // Number of rounds (last valid round-key index).
  function automatic logic [3:0] nr_f(input mode_e m);
    case (m)
      MODE_128: return 4'd10;
      MODE_192: return 4'd12;
      default:  return 4'd14;
    endcase
  endfunction

  // Total schedule length in words, 4*(Nr+1).
  function automatic logic [5:0] nwords_f(input mode_e m);
    case (m)
      MODE_128: return 6'd44;
      MODE_192: return 6'd52;
      default:  return 6'd60;
    endcase
  endfunction

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Cyclic left rotation of a word by one byte.
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Row-major table, entry 0 in the leftmost byte.
  localparam logic [0:2047] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_byte = SBOX_TABLE[{in_byte, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_expansion_iter.sv
// Iterative AES-128/192/256 key expander: one schedule word per cycle into a
// flop-based word store, exposed through an indexed port and a flat bus.
module aes_key_expansion_iter
  import aes_pkg::*;
#(
  parameter bit PIPE_SBOX = 1'b0,
  parameter bit FLAT_OUT  = 1'b1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               key_v_i,
  output logic               key_ready_o,
  input  logic [1:0]         mode_i,
  input  logic [0:255]       key_i,
  output logic               done_o,
  input  logic [3:0]         rk_idx_i,
  output logic [0:127]       rk_o,
  output logic               rk_valid_o,
  output logic [0:128*15-1]  round_keys_o
);

  state_e      state_reg, state_next;
  mode_e       mode_reg;
  mode_e       mode_in;
  logic [31:0] w_reg     [0:MAX_WORDS-1];
  logic [31:0] load_word [0:MAX_WORDS-1];
  logic [5:0]  wr_ptr_reg;
  logic [2:0]  kcnt_reg;     // i mod Nk for the word being produced
  logic [7:0]  rcon_reg;
  logic [31:0] sub_reg;

  logic        load, wr_en, sub_en;
  logic [3:0]  nk_in, nk_cur, nr_cur;
  logic [5:0]  nw_cur;
  logic [31:0] prev_word, old_word, sbox_in, sbox_out, sub_word, temp_word, new_word;
  logic        is_rot, is_sub_only, needs_sub;

  assign mode_in = mode_decode_f(mode_i);
  assign nk_in   = nk_f(mode_in);
  assign nk_cur  = nk_f(mode_reg);
  assign nr_cur  = nr_f(mode_reg);
  assign nw_cur  = nwords_f(mode_reg);

  // ---------------------------------------------------------------------
  // Word datapath: w[i] = w[i-Nk] ^ temp
  // ---------------------------------------------------------------------
  assign prev_word = w_reg[wr_ptr_reg - 6'd1];
  assign old_word  = w_reg[wr_ptr_reg - {2'b00, nk_cur}];

  assign is_rot      = (kcnt_reg == 3'd0);
  assign is_sub_only = (mode_reg == MODE_256) && (kcnt_reg == 3'd4);
  assign needs_sub   = is_rot | is_sub_only;

  assign sbox_in = is_rot ? rot_word(prev_word) : prev_word;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sbox
      aes_sbox u_sbox (
        .in_byte  (sbox_in[8*gi +: 8]),
        .out_byte (sbox_out[8*gi +: 8])
      );
    end
  endgenerate

  // With the pipelined S-box the write happens in SUBW from the captured value.
  assign sub_word  = PIPE_SBOX ? sub_reg : sbox_out;
  assign temp_word = !needs_sub ? prev_word
                   : (is_rot ? (sub_word ^ {rcon_reg, 24'h000000}) : sub_word);
  assign new_word  = old_word ^ temp_word;

  // Key words for the first Nk slots, zero everywhere else.
  generate
    for (gi = 0; gi < MAX_WORDS; gi++) begin : g_load
      if (gi < 8) begin : g_key
        assign load_word[gi] = (4'(gi) < nk_in) ? key_i[32*gi +: 32] : 32'h0;
      end else begin : g_zero
        assign load_word[gi] = 32'h0;
      end
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // Next state and datapath strobes; the extra EXPAND cycle that sees the
  // pointer at W is what moves the FSM to DONE.
  always_comb begin
    state_next  = state_reg;
    key_ready_o = 1'b0;
    load        = 1'b0;
    wr_en       = 1'b0;
    sub_en      = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        key_ready_o = 1'b1;
        if (key_v_i) begin
          load       = 1'b1;
          state_next = EXPAND;
        end
      end
      EXPAND: begin
        if (wr_ptr_reg == nw_cur) begin
          state_next = DONE;
        end else if (needs_sub && PIPE_SBOX) begin
          sub_en     = 1'b1;
          state_next = SUBW;
        end else begin
          wr_en = 1'b1;
        end
      end
      SUBW: begin
        wr_en      = 1'b1;
        state_next = EXPAND;
      end
      default: state_next = IDLE;
    endcase
  end

  assign done_o = (state_reg == DONE);

  // Mode latch, write pointer, modulo-Nk counter and round constant.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mode_reg   <= MODE_128;
      wr_ptr_reg <= 6'd0;
      kcnt_reg   <= 3'd0;
      rcon_reg   <= RCON_INIT;
    end else if (load) begin
      mode_reg   <= mode_in;
      wr_ptr_reg <= {2'b00, nk_in};
      kcnt_reg   <= 3'd0;
      rcon_reg   <= RCON_INIT;
    end else if (wr_en) begin
      wr_ptr_reg <= wr_ptr_reg + 6'd1;
      kcnt_reg   <= ({1'b0, kcnt_reg} == (nk_cur - 4'd1)) ? 3'd0 : kcnt_reg + 3'd1;
      if (is_rot) rcon_reg <= xtime(rcon_reg);
    end
  end

  // Captured S-box output for the two-cycle SubWord path.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)     sub_reg <= 32'h0;
    else if (sub_en) sub_reg <= sbox_out;
  end

  // Word store: cleared on reset, reloaded on accept, one write per step.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int j = 0; j < MAX_WORDS; j++) w_reg[j] <= 32'h0;
    end else if (load) begin
      for (int j = 0; j < MAX_WORDS; j++) w_reg[j] <= load_word[j];
    end else if (wr_en) begin
      w_reg[wr_ptr_reg] <= new_word;
    end
  end

  // ---------------------------------------------------------------------
  // Read side
  // ---------------------------------------------------------------------
  logic [127:0] rk_all [0:15];

  generate
    for (gi = 0; gi < MAX_RKEYS; gi++) begin : g_rk
      assign rk_all[gi] = {w_reg[4*gi], w_reg[4*gi+1], w_reg[4*gi+2], w_reg[4*gi+3]};
      if (FLAT_OUT) begin : g_flat
        assign round_keys_o[128*gi +: 128] = (4'(gi) <= nr_cur) ? rk_all[gi] : 128'h0;
      end else begin : g_noflat
        assign round_keys_o[128*gi +: 128] = 128'h0;
      end
    end
  endgenerate

  // Index 15 never names a real round key.
  assign rk_all[15] = 128'h0;

  assign rk_valid_o = done_o && (rk_idx_i <= nr_cur);
  assign rk_o       = rk_valid_o ? rk_all[rk_idx_i] : 128'h0;

endmodule

// File: tb/tb_aes_key_expansion_iter.sv
// Directed bench for aes_key_expansion_iter: two instances (combinational and
// pipelined S-box) share stimulus; expected round keys come from FIPS-197
// vectors and an independent reference schedule, queued per run.
module tb_aes_key_expansion_iter;

  logic           clk_i = 1'b0;
  logic           reset_i;
  logic           key_v_i;
  logic [1:0]     mode_i;
  logic [0:255]   key_i;
  logic [3:0]     rk_idx_i;

  logic           ready0, done0, rkv0;
  logic [0:127]   rk0;
  logic [0:1919]  rks0;
  logic           ready1, done1, rkv1;
  logic [0:127]   rk1;
  logic [0:1919]  rks1;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  aes_key_expansion_iter #(.PIPE_SBOX(1'b0), .FLAT_OUT(1'b1)) dut0 (
    .clk_i(clk_i), .reset_i(reset_i), .key_v_i(key_v_i), .key_ready_o(ready0),
    .mode_i(mode_i), .key_i(key_i), .done_o(done0), .rk_idx_i(rk_idx_i),
    .rk_o(rk0), .rk_valid_o(rkv0), .round_keys_o(rks0)
  );

  aes_key_expansion_iter #(.PIPE_SBOX(1'b1), .FLAT_OUT(1'b1)) dut1 (
    .clk_i(clk_i), .reset_i(reset_i), .key_v_i(key_v_i), .key_ready_o(ready1),
    .mode_i(mode_i), .key_i(key_i), .done_o(done1), .rk_idx_i(rk_idx_i),
    .rk_o(rk1), .rk_valid_o(rkv1), .round_keys_o(rks1)
  );

  // ---------------- reference model ----------------
  logic [7:0]  sbox_m [0:255];
  logic [31:0] mw     [0:59];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] subw_m(input logic [31:0] x);
    return {sbox_m[x[31:24]], sbox_m[x[23:16]], sbox_m[x[15:8]], sbox_m[x[7:0]]};
  endfunction

  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
      sbox_m[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                  {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [1:0] m, input logic [0:255] key);
    int nk, nw;
    logic [31:0] t;
    logic [7:0]  rc;
    nk = (m == 2'b00) ? 4 : (m == 2'b01) ? 6 : 8;
    nw = (m == 2'b00) ? 44 : (m == 2'b01) ? 52 : 60;
    rc = 8'h01;
    for (int i = 0; i < 60; i++) mw[i] = 32'h0;
    for (int i = 0; i < nk; i++) mw[i] = key[32*i +: 32];
    for (int i = nk; i < nw; i++) begin
      t = mw[i-1];
      if (i % nk == 0) begin
        t  = subw_m({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % 8 == 4) begin
        t = subw_m(t);
      end
      mw[i] = mw[i-nk] ^ t;
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    int           run;
    int           idx;
    logic [127:0] rk;
    logic [127:0] mask;
    logic         vld;
  } sb_t;
  sb_t sbq[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_model(input int run, input logic [1:0] m, input logic [0:255] key);
    int nr;
    model_expand(m, key);
    nr = (m == 2'b00) ? 10 : (m == 2'b01) ? 12 : 14;
    for (int idx = 0; idx < 16; idx++) begin
      sb_t e;
      e.run  = run;
      e.idx  = idx;
      e.vld  = (idx <= nr);
      e.mask = '1;
      e.rk   = 128'h0;
      if (idx <= nr) e.rk = {mw[4*idx], mw[4*idx+1], mw[4*idx+2], mw[4*idx+3]};
      sbq.push_back(e);
    end
  endtask

  task automatic push_kat(input int run, input int idx, input logic [127:0] rk,
                          input logic [127:0] mask);
    sb_t e;
    e.run = run; e.idx = idx; e.rk = rk; e.mask = mask; e.vld = 1'b1;
    sbq.push_back(e);
  endtask

  task automatic drain();
    sb_t e;
    logic [127:0] o;
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      rk_idx_i = 4'(e.idx);
      #1;
      o = rk0;
      chk($sformatf("r%0d_rk%0d_d0", e.run, e.idx), o & e.mask, e.rk & e.mask);
      o = rk1;
      chk($sformatf("r%0d_rk%0d_d1", e.run, e.idx), o & e.mask, e.rk & e.mask);
      chk($sformatf("r%0d_vld%0d_d0", e.run, e.idx), {127'b0, rkv0}, {127'b0, e.vld});
      chk($sformatf("r%0d_vld%0d_d1", e.run, e.idx), {127'b0, rkv1}, {127'b0, e.vld});
      if (e.idx < 15) begin
        o = rks0[128*e.idx +: 128];
        chk($sformatf("r%0d_slot%0d_d0", e.run, e.idx), o & e.mask, e.rk & e.mask);
        o = rks1[128*e.idx +: 128];
        chk($sformatf("r%0d_slot%0d_d1", e.run, e.idx), o & e.mask, e.rk & e.mask);
      end
      $display("run %0d idx %0d rk0=%h rk1=%h", e.run, e.idx, rk0, rk1);
    end
  endtask

  // Present one key, measure accept-to-done latency on both instances.
  task automatic run_key(input int run, input logic [1:0] m, input logic [0:255] key,
                         input int lat0_exp, input int lat1_exp, input bit pulse);
    int lat0, lat1;
    @(negedge clk_i);
    mode_i = m; key_i = key; key_v_i = 1'b1;
    @(posedge clk_i); #1;
    key_v_i = 1'b0;
    chk($sformatf("r%0d_acc_ready_d0", run), {127'b0, ready0}, 128'h0);
    chk($sformatf("r%0d_acc_ready_d1", run), {127'b0, ready1}, 128'h0);
    chk($sformatf("r%0d_acc_done_d0", run), {127'b0, done0}, 128'h0);
    chk($sformatf("r%0d_acc_done_d1", run), {127'b0, done1}, 128'h0);
    lat0 = 0; lat1 = 0;
    for (int c = 1; c <= 120 && (lat0 == 0 || lat1 == 0); c++) begin
      @(posedge clk_i); #1;
      if (lat0 == 0 && done0) lat0 = c;
      if (lat1 == 0 && done1) lat1 = c;
      if (c == 5) begin
        chk($sformatf("r%0d_busy_ready_d0", run), {127'b0, ready0}, 128'h0);
        chk($sformatf("r%0d_busy_ready_d1", run), {127'b0, ready1}, 128'h0);
      end
      if (pulse && c == 10) begin
        key_v_i = 1'b1; key_i = ~key; mode_i = 2'b00;
      end
      if (pulse && c == 11) key_v_i = 1'b0;
    end
    chk($sformatf("r%0d_latency_d0", run), 128'(lat0), 128'(lat0_exp));
    chk($sformatf("r%0d_latency_d1", run), 128'(lat1_exp == 0 ? 0 : lat1), 128'(lat1_exp));
    $display("run %0d mode %0d latency d0=%0d d1=%0d", run, m, lat0, lat1);
  endtask

  // ---------------- stimulus ----------------
  logic [0:255] k128, k192, k256, k64;
  logic [127:0] o;

  initial begin
    k128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    k192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    k64  = {32{8'h64}};
    build_sbox();

    reset_i = 1'b1; key_v_i = 1'b0; mode_i = 2'b00; key_i = '0; rk_idx_i = 4'd0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
    #1;
    chk("rst_ready_d0", {127'b0, ready0}, {127'b0, 1'b1});
    chk("rst_ready_d1", {127'b0, ready1}, {127'b0, 1'b1});
    chk("rst_done_d0", {127'b0, done0}, 128'h0);
    chk("rst_done_d1", {127'b0, done1}, 128'h0);
    chk("rst_rkv_d0", {127'b0, rkv0}, 128'h0);
    o = rk0;         chk("rst_rk_d0", o, 128'h0);
    o = rks0[0+:128]; chk("rst_slot0_d0", o, 128'h0);
    o = rks1[0+:128]; chk("rst_slot0_d1", o, 128'h0);

    // AES-128 with an ignored key_v pulse mid-expansion
    push_model(1, 2'b00, k128);
    push_kat(1, 1,  128'ha0fafe1788542cb123a339392a6c7605, '1);
    push_kat(1, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, '1);
    run_key(1, 2'b00, k128, 41, 51, 1'b1);
    drain();

    // AES-192
    push_model(2, 2'b01, k192);
    push_kat(2, 12, {96'h0, 32'h01002202}, {96'h0, 32'hffffffff});
    run_key(2, 2'b01, k192, 47, 55, 1'b0);
    drain();

    // AES-256
    push_model(3, 2'b10, k256);
    push_kat(3, 14, 128'hfe4890d1e6188d0b046df344706c631e, '1);
    run_key(3, 2'b10, k256, 53, 66, 1'b0);
    drain();

    // All-0x64 key, mode field 11 behaves as AES-256
    push_model(4, 2'b11, k64);
    run_key(4, 2'b11, k64, 53, 66, 1'b0);
    drain();

    // AES-128 accepted from DONE after an AES-256 schedule
    push_model(5, 2'b00, k128);
    push_kat(5, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, '1);
    run_key(5, 2'b00, k128, 41, 51, 1'b0);
    drain();

    // Asynchronous reset 20 cycles into an AES-256 expansion
    @(negedge clk_i);
    mode_i = 2'b10; key_i = k256; key_v_i = 1'b1;
    @(posedge clk_i); #1;
    key_v_i = 1'b0;
    repeat (20) @(posedge clk_i);
    #2;
    reset_i = 1'b1;
    #1;
    chk("arst_ready_d0", {127'b0, ready0}, {127'b0, 1'b1});
    chk("arst_ready_d1", {127'b0, ready1}, {127'b0, 1'b1});
    chk("arst_done_d0", {127'b0, done0}, 128'h0);
    chk("arst_done_d1", {127'b0, done1}, 128'h0);
    o = rk0; chk("arst_rk_d0", o, 128'h0);
    o = rk1; chk("arst_rk_d1", o, 128'h0);
    for (int s = 0; s < 15; s++) begin
      o = rks0[128*s +: 128]; chk($sformatf("arst_slot%0d_d0", s), o, 128'h0);
      o = rks1[128*s +: 128]; chk($sformatf("arst_slot%0d_d1", s), o, 128'h0);
    end
    $display("async reset mid-expand: ready0=%0d done0=%0d ready1=%0d done1=%0d",
             ready0, done0, ready1, done1);
    @(negedge clk_i);
    reset_i = 1'b0;

    // Fresh AES-128 after the reset
    push_kat(7, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, '1);
    push_model(7, 2'b00, k128);
    run_key(7, 2'b00, k128, 41, 51, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
